// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD time-of-day sequencer.
// Combinational only: no latency.
// No flow control: constants and a pure helper function.
package clock_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Digit indices in walk order.
  localparam logic [2:0] DIG_SEC_U  = 3'd0;
  localparam logic [2:0] DIG_SEC_T  = 3'd1;
  localparam logic [2:0] DIG_MIN_U  = 3'd2;
  localparam logic [2:0] DIG_MIN_T  = 3'd3;
  localparam logic [2:0] DIG_HOUR_U = 3'd4;
  localparam logic [2:0] DIG_HOUR_T = 3'd5;

  // Largest legal value of each kind of digit.
  localparam logic [3:0] LIM_UNITS     = 4'd9;
  localparam logic [3:0] LIM_TENS      = 4'd5;
  localparam logic [3:0] LIM_HOUR_T    = 4'd2;
  localparam logic [3:0] LIM_HOUR_U_20 = 4'd3;

  // Limit for a digit; hour units stop at 3 only in the twenties.
  function automatic logic [3:0] digit_limit(input logic [2:0] idx,
                                             input logic [3:0] hour_tens);
    logic [3:0] lim;
    case (idx)
      DIG_SEC_T, DIG_MIN_T: lim = LIM_TENS;
      DIG_HOUR_T:           lim = LIM_HOUR_T;
      DIG_HOUR_U:           lim = (hour_tens == LIM_HOUR_T) ? LIM_HOUR_U_20 : LIM_UNITS;
      default:              lim = LIM_UNITS;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/bcd_adder.sv
// Single-digit BCD adder with decimal correction.
// Combinational: zero latency.
// No flow control: result valid whenever operands are.
module bcd_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};

  // Add 6 to the binary sum when it passes 9 to get back into BCD.
  always_comb begin
    if (raw > 5'd9) begin
      cout = 1'b1;
      sum  = raw[3:0] + 4'd6;
    end else begin
      cout = 1'b0;
      sum  = raw[3:0];
    end
  end

endmodule

// File: rtl/bcd_time_sequencer.sv
// 24 h BCD clock: increments one digit per cycle through a shared BCD adder.
// Latency: request at edge N, digit k written at edge N+1+k, busy drops leaving FINISH.
// Backpressure: one pending tick while busy, a further tick is dropped; adjusts while busy are ignored.
module bcd_time_sequencer #(
  parameter logic [7:0] RESET_SEC  = 8'h00,
  parameter logic [7:0] RESET_MIN  = 8'h00,
  parameter logic [7:0] RESET_HOUR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       adj_min_req,
  input  logic       adj_hour_req,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       busy,
  output logic       day_carry,
  output logic       tick_dropped
);

  import clock_pkg::*;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [2:0] end_idx;
  logic       carry;
  logic       walk_tick;
  logic       pending;

  logic       start;
  logic       start_tick;
  logic [2:0] start_idx;
  logic [2:0] stop_idx;

  logic [3:0] cur_digit;
  logic [3:0] add_sum;
  logic       add_cout;
  logic [3:0] lim;
  logic       wrap;
  logic [3:0] new_digit;
  logic       last;

  // Select the digit currently being walked.
  always_comb begin
    cur_digit = sec_bcd[3:0];
    case (idx)
      DIG_SEC_U:  cur_digit = sec_bcd[3:0];
      DIG_SEC_T:  cur_digit = sec_bcd[7:4];
      DIG_MIN_U:  cur_digit = min_bcd[3:0];
      DIG_MIN_T:  cur_digit = min_bcd[7:4];
      DIG_HOUR_U: cur_digit = hour_bcd[3:0];
      DIG_HOUR_T: cur_digit = hour_bcd[7:4];
      default:    cur_digit = sec_bcd[3:0];
    endcase
  end

  bcd_adder u_adder (
    .a    (cur_digit),
    .b    (4'd0),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // A digit past its limit (or a decimal carry) wraps to 0 and keeps the carry alive.
  assign lim       = digit_limit(idx, hour_bcd[7:4]);
  assign wrap      = add_cout | (add_sum > lim);
  assign new_digit = wrap ? 4'd0 : add_sum;
  assign last      = (idx == end_idx);
  assign busy      = (state != IDLE);

  // Next-state and request arbitration: pending/new tick beats hour beats minute.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    start_tick = 1'b0;
    start_idx  = DIG_SEC_U;
    stop_idx   = DIG_HOUR_T;
    case (state)
      IDLE: begin
        if (pending || tick_1hz) begin
          start      = 1'b1;
          start_tick = 1'b1;
        end else if (adj_hour_req) begin
          start     = 1'b1;
          start_idx = DIG_HOUR_U;
        end else if (adj_min_req) begin
          start     = 1'b1;
          start_idx = DIG_MIN_U;
          stop_idx  = DIG_MIN_T;
        end
        if (start) begin
          state_nxt = WALK;
        end
      end
      WALK: begin
        if (!wrap || last) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Walk datapath, tick queueing and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_bcd      <= RESET_SEC;
      min_bcd      <= RESET_MIN;
      hour_bcd     <= RESET_HOUR;
      idx          <= DIG_SEC_U;
      end_idx      <= DIG_HOUR_T;
      carry        <= 1'b0;
      walk_tick    <= 1'b0;
      pending      <= 1'b0;
      day_carry    <= 1'b0;
      tick_dropped <= 1'b0;
    end else begin
      day_carry    <= 1'b0;
      tick_dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= start_idx;
            end_idx   <= stop_idx;
            carry     <= 1'b1;
            walk_tick <= start_tick;
          end
          // Serving the pending tick frees the slot for a tick arriving now.
          if (pending) begin
            pending <= tick_1hz;
          end
        end
        WALK: begin
          case (idx)
            DIG_SEC_U:  sec_bcd[3:0]  <= new_digit;
            DIG_SEC_T:  sec_bcd[7:4]  <= new_digit;
            DIG_MIN_U:  min_bcd[3:0]  <= new_digit;
            DIG_MIN_T:  min_bcd[7:4]  <= new_digit;
            DIG_HOUR_U: hour_bcd[3:0] <= new_digit;
            DIG_HOUR_T: hour_bcd[7:4] <= new_digit;
            default: ;
          endcase
          carry <= wrap;
          idx   <= idx + 3'd1;
          if (walk_tick && (idx == DIG_HOUR_T) && wrap) begin
            day_carry <= 1'b1;
          end
        end
        default: ;
      endcase
      if ((state != IDLE) && tick_1hz) begin
        if (pending) begin
          tick_dropped <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_time_sequencer.sv
// Directed bench for bcd_time_sequencer, reset time 23:59:59.
// Inputs driven on falling edges, outputs sampled on falling edges.
// Every wait on busy is bounded by a cycle budget.
module tb_bcd_time_sequencer;

  localparam int K_TICK = 0;
  localparam int K_MIN  = 1;
  localparam int K_HOUR = 2;
  localparam int NVEC   = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       adj_min_req = 1'b0;
  logic       adj_hour_req = 1'b0;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       busy;
  logic       day_carry;
  logic       tick_dropped;

  int tests = 0;
  int failed = 0;
  int drop_cnt = 0;
  int dc_cnt = 0;

  typedef struct {
    int         kind;
    int         reps;
    logic [23:0] exp_time;
    int         exp_busy;
    int         exp_dc;
  } vec_t;

  vec_t vecs [NVEC];

  bcd_time_sequencer #(
    .RESET_SEC  (8'h59),
    .RESET_MIN  (8'h59),
    .RESET_HOUR (8'h23)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .adj_min_req  (adj_min_req),
    .adj_hour_req (adj_hour_req),
    .sec_bcd      (sec_bcd),
    .min_bcd      (min_bcd),
    .hour_bcd     (hour_bcd),
    .busy         (busy),
    .day_carry    (day_carry),
    .tick_dropped (tick_dropped)
  );

  always #5 clk = ~clk;

  // Running totals of the one-cycle status pulses.
  always @(negedge clk) begin
    if (tick_dropped) drop_cnt++;
    if (day_carry) dc_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] now_time();
    return {8'h00, hour_bcd, min_bcd, sec_bcd};
  endfunction

  // One request pulse; returns busy length and day_carry pulses seen.
  task automatic press(input int kind, output int bcyc, output int dcn);
    int guard;
    @(negedge clk);
    case (kind)
      K_TICK:  tick_1hz = 1'b1;
      K_MIN:   adj_min_req = 1'b1;
      default: adj_hour_req = 1'b1;
    endcase
    @(negedge clk);
    tick_1hz = 1'b0;
    adj_min_req = 1'b0;
    adj_hour_req = 1'b0;
    bcyc = 0;
    dcn = 0;
    guard = 0;
    while (busy && guard < 40) begin
      bcyc++;
      if (day_carry) dcn++;
      @(negedge clk);
      guard++;
    end
    if (day_carry) dcn++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc;
    int dn;

    vecs[0]  = '{K_TICK,  1, 24'h000000, 7, 1};
    vecs[1]  = '{K_HOUR, 23, 24'h230000, 2, 0};
    vecs[2]  = '{K_MIN,  15, 24'h231500, 2, 0};
    vecs[3]  = '{K_HOUR,  1, 24'h001500, 3, 0};
    vecs[4]  = '{K_HOUR, 10, 24'h101500, 3, 0};
    vecs[5]  = '{K_MIN,  44, 24'h105900, 2, 0};
    vecs[6]  = '{K_TICK, 30, 24'h105930, 3, 0};
    vecs[7]  = '{K_MIN,   1, 24'h100030, 3, 0};
    vecs[8]  = '{K_HOUR,  2, 24'h120030, 2, 0};
    vecs[9]  = '{K_MIN,  34, 24'h123430, 2, 0};
    vecs[10] = '{K_TICK, 29, 24'h123459, 2, 0};
    vecs[11] = '{K_TICK,  1, 24'h123500, 4, 0};
    vecs[12] = '{K_HOUR, 21, 24'h093500, 2, 0};
    vecs[13] = '{K_MIN,  34, 24'h090900, 2, 0};
    vecs[14] = '{K_TICK,  9, 24'h090909, 2, 0};

    // Reset with every request asserted alongside it.
    tick_1hz = 1'b1;
    adj_min_req = 1'b1;
    adj_hour_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_time", now_time(), 32'h00235959);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {day_carry, tick_dropped}, 0);
    rst = 1'b0;
    tick_1hz = 1'b0;
    adj_min_req = 1'b0;
    adj_hour_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_reqs_ignored_busy", busy, 0);
    chk("rst_reqs_ignored_time", now_time(), 32'h00235959);

    // Reset in the middle of a 23:59:59 tick walk.
    @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0;
    @(negedge clk);
    chk("walk_digit0_written", sec_bcd, 8'h50);
    chk("walk_busy", busy, 1);
    rst = 1'b1;
    tick_1hz = 1'b1;
    adj_hour_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick_1hz = 1'b0;
    adj_hour_req = 1'b0;
    chk("midwalk_rst_time", now_time(), 32'h00235959);
    chk("midwalk_rst_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("midwalk_no_residue_busy", busy, 0);
    chk("midwalk_no_residue_time", now_time(), 32'h00235959);

    // Table: repeated pulses of one kind, last pulse measured.
    for (int i = 0; i < NVEC; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        press(vecs[i].kind, bc, dn);
      end
      chk($sformatf("v%0d_time", i), now_time(), {8'h00, vecs[i].exp_time});
      chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      chk($sformatf("v%0d_day_carry", i), dn, vecs[i].exp_dc);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end
    #2;
    chk("day_carry_total", dc_cnt, 1);
    chk("no_drops_yet", drop_cnt, 0);

    // Arbitration at 09:09:09 plus one queued and one dropped tick.
    @(negedge clk);
    tick_1hz = 1'b1;
    adj_min_req = 1'b1;
    adj_hour_req = 1'b1;
    @(negedge clk);
    adj_min_req = 1'b0;
    adj_hour_req = 1'b0;
    chk("arb_busy_walk", busy, 1);
    @(negedge clk);
    tick_1hz = 1'b0;
    @(negedge clk);
    tick_1hz = 1'b1;
    chk("arb_busy_finish", busy, 1);
    @(negedge clk);
    tick_1hz = 1'b0;
    chk("arb_time", now_time(), 32'h00090910);
    chk("arb_idle_gap", busy, 0);
    chk("arb_drop_pulse", tick_dropped, 1);
    bc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("pending_busy_cycles", bc, 2);
    chk("pending_time", now_time(), 32'h00090911);
    chk("pending_idle", busy, 0);
    #2;
    chk("drop_total", drop_cnt, 1);
    chk("day_carry_final", dc_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
